// File: rtl/chunk_pkg.sv
// Shared widths, FSM states and the job-to-chunk-bounds mapping for the chunk moments engine.
package chunk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  function automatic int id_w(input int n_chunks);
    return (2 * n_chunks > 2) ? $clog2(2 * n_chunks) : 1;
  endfunction

  function automatic int len_w(input int n_data);
    return (n_data > 1) ? $clog2(n_data + 1) : 1;
  endfunction

  function automatic int sum_w(input int data_w, input int n_data);
    return data_w + len_w(n_data);
  endfunction

  function automatic int sq_w(input int data_w, input int n_data);
    return 2 * data_w + len_w(n_data);
  endfunction

  // Forward jobs walk up from 0, backward jobs walk down from n_data; the last job of
  // each direction absorbs the remainder so neither end of the series is dropped.
  function automatic int chunk_si(input int id, input int n_data, input int n_chunks);
    int cs;
    int j;
    cs = n_data / n_chunks;
    j  = id - n_chunks;
    if (id < n_chunks) return id * cs;
    if (j == n_chunks - 1) return 0;
    return n_data - (j + 1) * cs;
  endfunction

  function automatic int chunk_ei(input int id, input int n_data, input int n_chunks);
    int cs;
    int j;
    cs = n_data / n_chunks;
    j  = id - n_chunks;
    if (id < n_chunks) return (id == n_chunks - 1) ? n_data : (id + 1) * cs;
    return n_data - j * cs;
  endfunction

endpackage

// File: rtl/chunk_moment_lane.sv
// One accumulation lane: streams a chunk's addresses, aligns returning data and holds the
// finished {id, len, sum, sumsq} until the output arbiter releases it.
module chunk_moment_lane import chunk_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int N_DATA   = 20,
  parameter int N_CHUNKS = 10,
  parameter int SIGNED   = 0,
  parameter int ID_W     = 5,
  parameter int LEN_W    = 5,
  parameter int SUM_W    = 37,
  parameter int SQ_W     = 69
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              assign_i,
  input  logic [ID_W-1:0]   id_i,
  input  logic              release_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              idle_o,
  output logic              pend_o,
  output logic [ID_W-1:0]   id_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [SUM_W-1:0]  sum_o,
  output logic [SQ_W-1:0]   sumsq_o
);

  logic              busy_q, pend_q, issue_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q, len_q;
  logic [ID_W-1:0]   id_q;
  logic              vld_p1, last_p1, vld_p2, last_p2;
  logic [DATA_W-1:0] data_p2;
  logic signed [SUM_W-1:0] sum_q;
  logic [SQ_W-1:0]   sumsq_q;
  int                si_d, ei_d;

  function automatic logic signed [DATA_W:0] ext_sample(input logic [DATA_W-1:0] d);
    return {(SIGNED != 0) ? d[DATA_W-1] : 1'b0, d};
  endfunction

  function automatic logic signed [SUM_W-1:0] widen(input logic signed [DATA_W:0] s);
    logic signed [SUM_W-1:0] r;
    r = {SUM_W{s[DATA_W]}};
    r[DATA_W:0] = s;
    return r;
  endfunction

  // Squared at full width; the low 2*DATA_W bits are exact for both signednesses.
  function automatic logic [2*DATA_W-1:0] square(input logic signed [DATA_W:0] s);
    logic [2*DATA_W+1:0] a, p;
    a = {{(DATA_W+1){s[DATA_W]}}, s};
    p = a * a;
    return p[2*DATA_W-1:0];
  endfunction

  always_comb begin
    si_d = chunk_si(int'(id_i), N_DATA, N_CHUNKS);
    ei_d = chunk_ei(int'(id_i), N_DATA, N_CHUNKS);
  end

  // p0: address issue; p1: rd_data on the bus; p2: registered sample into the accumulators
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      issue_q <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      vld_p1  <= issue_q;
      last_p1 <= issue_q && (rem_q == LEN_W'(1));
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      if (assign_i) begin
        busy_q  <= 1'b1;
        issue_q <= 1'b1;
        addr_q  <= ADDR_W'(si_d);
        rem_q   <= LEN_W'(ei_d - si_d);
        len_q   <= LEN_W'(ei_d - si_d);
        id_q    <= id_i;
      end else if (issue_q) begin
        if (rem_q == LEN_W'(1)) begin
          issue_q <= 1'b0;
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
          rem_q  <= rem_q - LEN_W'(1);
        end
      end
      if (vld_p2 && last_p2) begin
        busy_q <= 1'b0;
        pend_q <= 1'b1;
      end
      if (release_i) pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    data_p2 <= rd_data_i;
    if (assign_i) begin
      sum_q   <= '0;
      sumsq_q <= '0;
    end else if (vld_p2) begin
      sum_q   <= sum_q + widen(ext_sample(data_p2));
      sumsq_q <= sumsq_q + {{LEN_W{1'b0}}, square(ext_sample(data_p2))};
    end
  end

  assign rd_en_o   = issue_q;
  assign rd_addr_o = addr_q;
  assign idle_o    = !busy_q && !pend_q;
  assign pend_o    = pend_q;
  assign id_o      = id_q;
  assign len_o     = len_q;
  assign sum_o     = sum_q;
  assign sumsq_o   = sumsq_q;

endmodule

// File: rtl/chunk_moments_engine.sv
// Top level: run FSM and job counter, lowest-idle lane allocator, and a round-robin
// registered output stage over the lanes' pending results.
module chunk_moments_engine import chunk_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int N_DATA   = 20,
  parameter int N_CHUNKS = 10,
  parameter int N_LANES  = 4,
  parameter int SIGNED   = 0,
  localparam int ID_W    = id_w(N_CHUNKS),
  localparam int LEN_W   = len_w(N_DATA),
  localparam int SUM_W   = sum_w(DATA_W, N_DATA),
  localparam int SQ_W    = sq_w(DATA_W, N_DATA)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [N_LANES-1:0]        rd_en,
  output logic [N_LANES*ADDR_W-1:0] rd_addr,
  input  logic [N_LANES*DATA_W-1:0] rd_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ID_W-1:0]           res_id,
  output logic [LEN_W-1:0]          res_len,
  output logic [SUM_W-1:0]          res_sum,
  output logic [SQ_W-1:0]           res_sumsq
);

  localparam int NJOBS  = 2 * N_CHUNKS;
  localparam int JOB_W  = $clog2(NJOBS + 1);
  localparam int LIDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  state_e             state_q;
  logic               busy_q, done_q;
  logic [JOB_W-1:0]   job_q;

  logic [N_LANES-1:0] lane_assign, lane_release, lane_idle, lane_pend;
  logic [ID_W-1:0]    lane_id    [N_LANES];
  logic [LEN_W-1:0]   lane_len   [N_LANES];
  logic [SUM_W-1:0]   lane_sum   [N_LANES];
  logic [SQ_W-1:0]    lane_sumsq [N_LANES];

  logic               alloc_found, gnt_found, xfer;
  logic [LIDX_W-1:0]  alloc_idx, gnt_idx, gnt_q, rr_ptr_q;
  int                 rr_k;
  logic [ID_W-1:0]    sel_id;
  logic [LEN_W-1:0]   sel_len;
  logic [SUM_W-1:0]   sel_sum;
  logic [SQ_W-1:0]    sel_sumsq;

  logic               res_valid_q;
  logic [ID_W-1:0]    res_id_q;
  logic [LEN_W-1:0]   res_len_q;
  logic [SUM_W-1:0]   res_sum_q;
  logic [SQ_W-1:0]    res_sumsq_q;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    chunk_moment_lane #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_DATA(N_DATA), .N_CHUNKS(N_CHUNKS),
      .SIGNED(SIGNED), .ID_W(ID_W), .LEN_W(LEN_W), .SUM_W(SUM_W), .SQ_W(SQ_W)
    ) u_lane (
      .clk_i    (Clk),
      .rst_i    (Rst),
      .assign_i (lane_assign[g]),
      .id_i     (job_q[ID_W-1:0]),
      .release_i(lane_release[g]),
      .rd_en_o  (rd_en[g]),
      .rd_addr_o(rd_addr[g*ADDR_W +: ADDR_W]),
      .rd_data_i(rd_data[g*DATA_W +: DATA_W]),
      .idle_o   (lane_idle[g]),
      .pend_o   (lane_pend[g]),
      .id_o     (lane_id[g]),
      .len_o    (lane_len[g]),
      .sum_o    (lane_sum[g]),
      .sumsq_o  (lane_sumsq[g])
    );
  end

  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (!alloc_found && lane_idle[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = LIDX_W'(i);
      end
    end
  end

  // Search starts at the lane after the last one granted so no lane can be starved.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_k      = 0;
    sel_id    = '0;
    sel_len   = '0;
    sel_sum   = '0;
    sel_sumsq = '0;
    for (int i = 0; i < N_LANES; i++) begin
      rr_k = int'(rr_ptr_q) + i;
      if (rr_k >= N_LANES) rr_k = rr_k - N_LANES;
      if (!gnt_found && lane_pend[rr_k]) begin
        gnt_found = 1'b1;
        gnt_idx   = LIDX_W'(rr_k);
        sel_id    = lane_id[rr_k];
        sel_len   = lane_len[rr_k];
        sel_sum   = lane_sum[rr_k];
        sel_sumsq = lane_sumsq[rr_k];
      end
    end
  end

  assign xfer = res_valid_q && res_ready;

  always_comb begin
    lane_assign  = '0;
    lane_release = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane_assign[i]  = (state_q == ST_DISPATCH) && alloc_found && (alloc_idx == LIDX_W'(i));
      lane_release[i] = xfer && (gnt_q == LIDX_W'(i));
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      job_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A start coinciding with the done pulse belongs to the finished run.
          if (start && !done_q) begin
            busy_q  <= 1'b1;
            job_q   <= '0;
            state_q <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (alloc_found) begin
            job_q <= job_q + JOB_W'(1);
            if (job_q == JOB_W'(NJOBS - 1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (&lane_idle) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_len_q   <= '0;
      res_sum_q   <= '0;
      res_sumsq_q <= '0;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
    end else if (xfer) begin
      res_valid_q <= 1'b0;
      rr_ptr_q    <= (gnt_q == LIDX_W'(N_LANES - 1)) ? '0 : gnt_q + LIDX_W'(1);
    end else if (!res_valid_q && gnt_found) begin
      res_valid_q <= 1'b1;
      gnt_q       <= gnt_idx;
      res_id_q    <= sel_id;
      res_len_q   <= sel_len;
      res_sum_q   <= sel_sum;
      res_sumsq_q <= sel_sumsq;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_len   = res_len_q;
  assign res_sum   = res_sum_q;
  assign res_sumsq = res_sumsq_q;

endmodule
